mem_list_agent: RTL and testbench
=================================

// Module: mem_list_agent
// PURPOSE
// - Initiator on the 16-bit word memory port: walks one count-prefixed list (count word + contiguous word array).
// - READ streams every element over valid/ready; APPEND writes one element at the list tail and bumps the count.
// - Sits between routing/cluster control logic and mem; serves knownSinks, neighborID, betterneighbors, etc.
// PARAMETERS
// - ADDR_W       11   byte-address width of the memory port
// - WORD_W       16   word width; memory stores each word as two bytes, high byte first
// - MAX_ENTRIES  64   largest legal count; larger stored count is an error
// PORTS
// - clock         in   1        single clock, all state on posedge
// - nrst          in   1        asynchronous, active-low reset
// - cmd_valid     in   1        command request
// - cmd_ready     out  1        high only in IDLE; command taken when cmd_valid & cmd_ready
// - cmd_op        in   1        0 = READ, 1 = APPEND
// - cmd_base      in   ADDR_W   byte address of element 0
// - cmd_cnt_addr  in   ADDR_W   byte address of the count word
// - cmd_wdata     in   WORD_W   element to append (ignored for READ)
// - out_valid     out  1        streamed element valid
// - out_ready     in   1        consumer accepts when out_valid & out_ready
// - out_data      out  WORD_W   element value
// - out_index     out  6        element index, 0-based
// - out_last      out  1        high with the final element
// - done          out  1        one-cycle pulse at command end
// - err           out  1        registered with done: count > MAX_ENTRIES (READ) or >= MAX_ENTRIES (APPEND)
// - mem_address   out  ADDR_W   to mem address
// - mem_wr_en     out  1        to mem wr_en
// - mem_data_in   out  WORD_W   to mem data_in
// - mem_data_out  in   WORD_W   from mem data_out (combinational read of current mem_address)
// BEHAVIOUR
// - Reset (async, nrst=0): state IDLE; cmd_ready=1 after release; all other outputs 0; count/index regs 0.
// - mem_* outputs are decoded from registered state/regs only; no input-to-output combinational path.
// - Reads sample mem_data_out at the clock edge ending the cycle in which mem_address is driven.
// - States: IDLE, FETCH_CNT, FETCH_ELEM, HOLD, WRITE_ELEM, WRITE_CNT, DONE.
// - IDLE: accept command, latch base/cnt_addr/wdata/op -> FETCH_CNT.
// - FETCH_CNT: mem_address=cnt_addr; latch count.
//   - READ: count=0 -> DONE (err=0); count>MAX_ENTRIES -> DONE (err=1); else i=0 -> FETCH_ELEM.
//   - APPEND: count>=MAX_ENTRIES -> DONE (err=1, no write); else -> WRITE_ELEM.
// - FETCH_ELEM: mem_address=base+2*i; latch out_data, out_index=i, out_last=(i==count-1) -> HOLD.
// - HOLD: out_valid=1; out_data/index/last stable until accepted; on accept: last -> DONE else i++ -> FETCH_ELEM.
// - WRITE_ELEM: mem_address=base+2*count, mem_data_in=wdata, mem_wr_en=1 (one cycle) -> WRITE_CNT.
// - WRITE_CNT: mem_address=cnt_addr, mem_data_in=count+1, mem_wr_en=1 (one cycle) -> DONE.
// - DONE: done=1 one cycle, err valid same cycle -> IDLE. Latency: READ count=0 done 3 cycles after accept.
// - Throughput: 2 cycles/element minimum (FETCH_ELEM + HOLD with out_ready high).
// - Address arithmetic modulo 2^ADDR_W (wraps silently); index fits 6 bits since count <= 64.
// - mem_wr_en never high outside WRITE_ELEM/WRITE_CNT; cmd_valid while busy is ignored (not queued).
// - Reset mid-operation: immediate IDLE; a write in flight is dropped; list may hold element without count bump.
// STRUCTURE
// - Shared package mem_map_pkg: list base/count address constants (KNOWN_SINKS 0x008, WORST_HOPS 0x028,
//   NEIGHBOR_ID 0x048, CLUSTER_ID 0x0C8, BETTER_NEIGHBORS 0x668, KNOWN_SINK_COUNT 0x688,
//   NEIGHBOR_COUNT 0x68A, BETTER_NEIGHBOR_COUNT 0x68C), op codes, state enum.
// - Single flat module; no sub-module. Bench instantiates mem as the responder.
// TESTING
// - READ base=0x008 cnt=0x688 (count 5), out_ready=1 -> out_data 2,5,10,171,205, index 0..4, last on 205, done, err=0.
// - Same READ, out_ready low 3 cycles in HOLD of element 1 -> out_data=5 stable, no index skip, no extra mem write.
// - READ cnt=0x68C (count 0) -> no out_valid, done 3 cycles after accept, err=0.
// - APPEND 0x00DE to knownSinks (count 5) -> write 0x00DE at 0x012, then count 6 at 0x688; READ returns 6 elements.
// - APPEND with count word = 64 -> err=1 with done, mem_wr_en never asserted; count=65 READ -> err=1, no stream.
// - nrst low during HOLD of element 2 -> all outputs 0 immediately, IDLE, cmd_ready=1 after release, next READ clean.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants for the list agent: list base/count addresses,
// command op codes and FSM state encodings.
package mem_map_pkg;

  localparam logic [10:0] KNOWN_SINKS           = 11'h008;
  localparam logic [10:0] WORST_HOPS            = 11'h028;
  localparam logic [10:0] NEIGHBOR_ID           = 11'h048;
  localparam logic [10:0] CLUSTER_ID            = 11'h0C8;
  localparam logic [10:0] BETTER_NEIGHBORS      = 11'h668;
  localparam logic [10:0] KNOWN_SINK_COUNT      = 11'h688;
  localparam logic [10:0] NEIGHBOR_COUNT        = 11'h68A;
  localparam logic [10:0] BETTER_NEIGHBOR_COUNT = 11'h68C;

  localparam logic OP_READ   = 1'b0;
  localparam logic OP_APPEND = 1'b1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH_CNT  = 3'd1;
  localparam logic [2:0] ST_FETCH_ELEM = 3'd2;
  localparam logic [2:0] ST_HOLD       = 3'd3;
  localparam logic [2:0] ST_WRITE_ELEM = 3'd4;
  localparam logic [2:0] ST_WRITE_CNT  = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

endpackage

// File: rtl/mem_list_agent.sv
// Memory-port initiator that walks one count-prefixed word list: READ streams
// every element over valid/ready, APPEND writes the tail element and bumps the count.
module mem_list_agent
  import mem_map_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int WORD_W      = 16,
  parameter int MAX_ENTRIES = 64
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_cnt_addr,
  input  logic [WORD_W-1:0] cmd_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [5:0]        out_index,
  output logic              out_last,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr_en,
  output logic [WORD_W-1:0] mem_data_in,
  input  logic [WORD_W-1:0] mem_data_out
);

  localparam logic [WORD_W-1:0] MAX_CNT = WORD_W'(MAX_ENTRIES);
  localparam logic [WORD_W-1:0] ONE_W   = {{(WORD_W-1){1'b0}}, 1'b1};
  localparam logic [WORD_W-1:0] ZERO_W  = {WORD_W{1'b0}};

  // Element i lives two bytes per word past the base; the sum wraps silently.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [5:0]        idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

  logic [2:0]        state_r, state_next;
  logic              op_r;
  logic [ADDR_W-1:0] base_r, cnt_addr_r;
  logic [WORD_W-1:0] wdata_r;
  logic [WORD_W-1:0] count_r, count_next;
  logic [5:0]        idx_r, idx_next;
  logic              err_next;
  logic              accept_s;

  logic              cmd_ready_r, out_valid_r, out_last_r, done_r, err_r;
  logic [WORD_W-1:0] out_data_r;
  logic [5:0]        out_index_r;
  logic [ADDR_W-1:0] mem_address_r, mem_address_next;
  logic              mem_wr_en_r, mem_wr_en_next;
  logic [WORD_W-1:0] mem_data_in_r, mem_data_in_next;

  assign accept_s = cmd_valid & cmd_ready_r;

  // Next-state, index and count decode.
  always_comb begin
    state_next = state_r;
    idx_next   = idx_r;
    count_next = count_r;
    err_next   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next = ST_FETCH_CNT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FETCH_CNT: begin
        count_next = mem_data_out;
        if (op_r == OP_APPEND) begin
          if (mem_data_out >= MAX_CNT) begin
            state_next = ST_DONE;
            err_next   = 1'b1;
          end else begin
            state_next = ST_WRITE_ELEM;
          end
        end else begin
          if (mem_data_out == ZERO_W) begin
            state_next = ST_DONE;
          end else if (mem_data_out > MAX_CNT) begin
            state_next = ST_DONE;
            err_next   = 1'b1;
          end else begin
            idx_next   = 6'd0;
            state_next = ST_FETCH_ELEM;
          end
        end
      end
      ST_FETCH_ELEM: state_next = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          if (out_last_r) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_r + 6'd1;
            state_next = ST_FETCH_ELEM;
          end
        end else begin
          state_next = ST_HOLD;
        end
      end
      ST_WRITE_ELEM: state_next = ST_WRITE_CNT;
      ST_WRITE_CNT:  state_next = ST_DONE;
      ST_DONE:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // Memory port values for the state being entered, so they register cleanly.
  always_comb begin
    mem_address_next = {ADDR_W{1'b0}};
    mem_wr_en_next   = 1'b0;
    mem_data_in_next = ZERO_W;
    case (state_next)
      ST_FETCH_CNT:  mem_address_next = cmd_cnt_addr;
      ST_FETCH_ELEM: mem_address_next = elem_addr(base_r, idx_next);
      ST_WRITE_ELEM: begin
        mem_address_next = elem_addr(base_r, count_next[5:0]);
        mem_wr_en_next   = 1'b1;
        mem_data_in_next = wdata_r;
      end
      ST_WRITE_CNT: begin
        mem_address_next = cnt_addr_r;
        mem_wr_en_next   = 1'b1;
        mem_data_in_next = count_next + ONE_W;
      end
      default: mem_address_next = {ADDR_W{1'b0}};
    endcase
  end

  // State, command latches and all registered outputs.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_r       <= ST_IDLE;
      op_r          <= OP_READ;
      base_r        <= {ADDR_W{1'b0}};
      cnt_addr_r    <= {ADDR_W{1'b0}};
      wdata_r       <= ZERO_W;
      count_r       <= ZERO_W;
      idx_r         <= 6'd0;
      cmd_ready_r   <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= ZERO_W;
      out_index_r   <= 6'd0;
      out_last_r    <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      mem_address_r <= {ADDR_W{1'b0}};
      mem_wr_en_r   <= 1'b0;
      mem_data_in_r <= ZERO_W;
    end else begin
      state_r     <= state_next;
      count_r     <= count_next;
      idx_r       <= idx_next;
      cmd_ready_r <= (state_next == ST_IDLE);
      if (accept_s) begin
        op_r       <= cmd_op;
        base_r     <= cmd_base;
        cnt_addr_r <= cmd_cnt_addr;
        wdata_r    <= cmd_wdata;
      end
      // The element word is on mem_data_out during FETCH_ELEM; hold it for the handshake.
      if (state_r == ST_FETCH_ELEM) begin
        out_data_r  <= mem_data_out;
        out_index_r <= idx_r;
        out_last_r  <= ({{(WORD_W-6){1'b0}}, idx_r} == (count_r - ONE_W));
      end
      out_valid_r   <= (state_next == ST_HOLD);
      done_r        <= (state_next == ST_DONE);
      err_r         <= err_next;
      mem_address_r <= mem_address_next;
      mem_wr_en_r   <= mem_wr_en_next;
      mem_data_in_r <= mem_data_in_next;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_index   = out_index_r;
  assign out_last    = out_last_r;
  assign done        = done_r;
  assign err         = err_r;
  assign mem_address = mem_address_r;
  assign mem_wr_en   = mem_wr_en_r;
  assign mem_data_in = mem_data_in_r;

endmodule

// File: tb/tb_mem_list_agent.sv
// Directed bench for mem_list_agent: a byte-wide memory model answers the port,
// a monitor records stream handshakes and memory writes.
module tb_mem_list_agent;
  import mem_map_pkg::*;

  logic        clock = 1'b0;
  logic        nrst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [10:0] cmd_base, cmd_cnt_addr;
  logic [15:0] cmd_wdata;
  logic        out_valid, out_ready, out_last, done, err;
  logic [15:0] out_data;
  logic [5:0]  out_index;
  logic [10:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_data_in, mem_data_out;

  logic        bd_en;
  logic [10:0] bd_addr;
  logic [15:0] bd_data;
  logic [7:0]  mem [0:2047];

  int checks = 0;
  int failures = 0;

  logic [15:0] rd_data_q[$];
  logic [5:0]  rd_idx_q[$];
  logic        rd_last_q[$];
  logic [10:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  logic [15:0] exp_list [6] = '{16'd2, 16'd5, 16'd10, 16'd171, 16'd205, 16'h00DE};

  mem_list_agent dut (
    .clock(clock), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_cnt_addr(cmd_cnt_addr), .cmd_wdata(cmd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done), .err(err),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  assign mem_data_out = {mem[mem_address], mem[mem_address + 11'd1]};

  // Memory model (high byte first) plus handshake/write logging.
  always @(posedge clock) begin
    if (bd_en) begin
      mem[bd_addr]         <= bd_data[15:8];
      mem[bd_addr + 11'd1] <= bd_data[7:0];
    end
    if (mem_wr_en) begin
      mem[mem_address]         <= mem_data_in[15:8];
      mem[mem_address + 11'd1] <= mem_data_in[7:0];
      wr_addr_q.push_back(mem_address);
      wr_data_q.push_back(mem_data_in);
    end
    if (out_valid && out_ready) begin
      rd_data_q.push_back(out_data);
      rd_idx_q.push_back(out_index);
      rd_last_q.push_back(out_last);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input logic [10:0] a, input logic [15:0] d);
    @(negedge clock);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clock);
    bd_en = 1'b0;
  endtask

  function automatic logic [15:0] get_word(input logic [10:0] a);
    return {mem[a], mem[a + 11'd1]};
  endfunction

  task automatic clear_logs();
    rd_data_q.delete(); rd_idx_q.delete(); rd_last_q.delete();
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  // Returns at the negedge after the accepting posedge (state FETCH_CNT).
  task automatic issue_cmd(input logic op, input logic [10:0] base, input logic [10:0] cnt,
                           input logic [15:0] wd);
    int n = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_cnt_addr = cnt; cmd_wdata = wd;
    while (!cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, {31'd0, out_valid}, 32'd1);
  endtask

  // Waits for done, returns err, then checks the pulse drops and cmd_ready returns.
  task automatic wait_done(input string tag, output logic err_seen);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    err_seen = err;
    @(negedge clock);
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic check_stream(input string tag, input int n);
    check_eq({tag, "_len"}, rd_data_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), {16'd0, rd_data_q[i]}, {16'd0, exp_list[i]});
      check_eq($sformatf("%s_idx%0d", tag, i), {26'd0, rd_idx_q[i]}, i);
      check_eq($sformatf("%s_last%0d", tag, i), {31'd0, rd_last_q[i]}, (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    check_eq({tag, "_out_index"}, {26'd0, out_index}, 32'd0);
    check_eq({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
    check_eq({tag, "_mem_address"}, {21'd0, mem_address}, 32'd0);
    check_eq({tag, "_mem_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    check_eq({tag, "_mem_data_in"}, {16'd0, mem_data_in}, 32'd0);
  endtask

  initial begin
    logic e;
    nrst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_READ; cmd_base = 11'd0;
    cmd_cnt_addr = 11'd0; cmd_wdata = 16'd0; out_ready = 1'b0;
    bd_en = 1'b0; bd_addr = 11'd0; bd_data = 16'd0;

    #1;
    check_all_zero("rst");
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (2) @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    check_eq("rst_release_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 5; i++) set_word(KNOWN_SINKS + 11'(2 * i), exp_list[i]);
    set_word(KNOWN_SINK_COUNT, 16'd5);
    set_word(BETTER_NEIGHBOR_COUNT, 16'd0);
    set_word(NEIGHBOR_COUNT, 16'd64);

    // READ of five elements, consumer always ready.
    clear_logs();
    out_ready = 1'b1;
    issue_cmd(OP_READ, KNOWN_SINKS, KNOWN_SINK_COUNT, 16'h0000);
    wait_done("read5", e);
    check_eq("read5_err", {31'd0, e}, 32'd0);
    check_stream("read5", 5);
    check_eq("read5_no_write", wr_addr_q.size(), 0);

    // Same READ with a three-cycle stall on element 1.
    clear_logs();
    out_ready = 1'b0;
    issue_cmd(OP_READ, KNOWN_SINKS, KNOWN_SINK_COUNT, 16'h0000);
    wait_valid("stall_elem0_valid");
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    wait_valid("stall_elem1_valid");
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("stall_valid_c%0d", k), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("stall_data_c%0d", k), {16'd0, out_data}, 32'd5);
      check_eq($sformatf("stall_index_c%0d", k), {26'd0, out_index}, 32'd1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    wait_done("stall", e);
    check_eq("stall_err", {31'd0, e}, 32'd0);
    check_stream("stall", 5);
    check_eq("stall_no_write", wr_addr_q.size(), 0);

    // Empty list: done in the third cycle counting the accept cycle, no stream.
    clear_logs();
    issue_cmd(OP_READ, BETTER_NEIGHBORS, BETTER_NEIGHBOR_COUNT, 16'h0000);
    check_eq("empty_done_early", {31'd0, done}, 32'd0);
    @(negedge clock);
    check_eq("empty_done_lat", {31'd0, done}, 32'd1);
    check_eq("empty_err", {31'd0, err}, 32'd0);
    @(negedge clock);
    check_eq("empty_done_pulse", {31'd0, done}, 32'd0);
    check_eq("empty_no_stream", rd_data_q.size(), 0);

    // APPEND 0x00DE: tail write at 0x012 then count 6.
    clear_logs();
    issue_cmd(OP_APPEND, KNOWN_SINKS, KNOWN_SINK_COUNT, 16'h00DE);
    wait_done("append", e);
    check_eq("append_err", {31'd0, e}, 32'd0);
    check_eq("append_wr_count", wr_addr_q.size(), 2);
    check_eq("append_wr0_addr", {21'd0, wr_addr_q[0]}, 32'h012);
    check_eq("append_wr0_data", {16'd0, wr_data_q[0]}, 32'h00DE);
    check_eq("append_wr1_addr", {21'd0, wr_addr_q[1]}, 32'h688);
    check_eq("append_wr1_data", {16'd0, wr_data_q[1]}, 32'd6);
    check_eq("append_mem_count", {16'd0, get_word(KNOWN_SINK_COUNT)}, 32'd6);
    clear_logs();
    issue_cmd(OP_READ, KNOWN_SINKS, KNOWN_SINK_COUNT, 16'h0000);
    wait_done("read6", e);
    check_eq("read6_err", {31'd0, e}, 32'd0);
    check_stream("read6", 6);

    // APPEND on a full list (64) is refused without any write.
    clear_logs();
    issue_cmd(OP_APPEND, NEIGHBOR_ID, NEIGHBOR_COUNT, 16'h1234);
    wait_done("full_append", e);
    check_eq("full_append_err", {31'd0, e}, 32'd1);
    check_eq("full_append_no_write", wr_addr_q.size(), 0);
    check_eq("full_append_count", {16'd0, get_word(NEIGHBOR_COUNT)}, 32'd64);

    // Stored count 65 is illegal for READ.
    set_word(NEIGHBOR_COUNT, 16'd65);
    clear_logs();
    issue_cmd(OP_READ, NEIGHBOR_ID, NEIGHBOR_COUNT, 16'h0000);
    wait_done("over_read", e);
    check_eq("over_read_err", {31'd0, e}, 32'd1);
    check_eq("over_read_no_stream", rd_data_q.size(), 0);

    // Reset while element 2 is held.
    clear_logs();
    out_ready = 1'b0;
    issue_cmd(OP_READ, KNOWN_SINKS, KNOWN_SINK_COUNT, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      wait_valid($sformatf("mid_rst_valid%0d", k));
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
    end
    wait_valid("mid_rst_valid2");
    check_eq("mid_rst_hold_index", {26'd0, out_index}, 32'd2);
    nrst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    check_eq("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_ready_back", {31'd0, cmd_ready}, 32'd1);
    check_eq("mid_rst_idle_valid", {31'd0, out_valid}, 32'd0);
    clear_logs();
    out_ready = 1'b1;
    issue_cmd(OP_READ, KNOWN_SINKS, KNOWN_SINK_COUNT, 16'h0000);
    wait_done("post_rst", e);
    check_eq("post_rst_err", {31'd0, e}, 32'd0);
    check_stream("post_rst", 6);
    check_eq("post_rst_no_write", wr_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
